// File: rtl/music_player_if.sv
// Control, score-ROM and audio signals of the music player, grouped for port hookup.
interface music_player_if;
    logic        play;
    logic        restart;
    logic        loop_en;
    logic [31:0] tone_in;
    logic [7:0]  beat_num;
    logic        audio_out;
    logic        beat_tick;
    logic        playing;
    logic        song_done;

    modport master (
        output play, restart, loop_en, tone_in,
        input  beat_num, audio_out, beat_tick, playing, song_done
    );

    modport slave (
        input  play, restart, loop_en, tone_in,
        output beat_num, audio_out, beat_tick, playing, song_done
    );
endinterface

// File: rtl/music_player.sv
// Beat sequencer for a combinational score ROM plus a phase-accumulator
// square-wave synthesiser with play/pause/restart/loop control.
module music_player #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BEAT_RATE = 8,
    parameter int unsigned LAST_BEAT = 117,
    parameter int unsigned MUTE_TONE = 20000
) (
    input  logic           clk,
    input  logic           rst_n,
    music_player_if.slave  bus
);
    localparam int unsigned DIV   = CLK_FREQ / BEAT_RATE;
    localparam int unsigned HALF  = CLK_FREQ / 2;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       beat_num;
    logic [31:0]      acc;
    logic [31:0]      tone_q;
    logic             audio;
    logic             beat_tick;
    logic             playing;
    logic             song_done;

    logic [32:0] sum;
    logic        mute;
    logic        tone_chg;
    logic        div_end;

    // 33-bit sum so acc + tone_q can never wrap before the HALF compare
    assign sum      = {1'b0, acc} + {1'b0, tone_q};
    assign mute     = (tone_q == 32'(MUTE_TONE)) || (tone_q == 32'd0) || (tone_q >= 32'(HALF));
    assign tone_chg = bus.tone_in != tone_q;
    assign div_end  = div_cnt == DIV_W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            beat_num  <= '0;
            acc       <= '0;
            tone_q    <= '0;
            audio     <= 1'b0;
            beat_tick <= 1'b0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else if (bus.restart) begin
            state     <= IDLE;
            div_cnt   <= '0;
            beat_num  <= '0;
            acc       <= '0;
            tone_q    <= '0;
            audio     <= 1'b0;
            beat_tick <= 1'b0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            beat_tick <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    beat_num <= '0;
                    acc      <= '0;
                    audio    <= 1'b0;
                    if (bus.play) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!bus.play) begin
                        // pause beats a coincident tick: divider and beat hold as-is
                        state   <= PAUSE;
                        playing <= 1'b0;
                        audio   <= 1'b0;
                    end else begin
                        tone_q <= bus.tone_in;
                        // a new note starts phase-aligned low
                        if (tone_chg || mute) begin
                            acc   <= '0;
                            audio <= 1'b0;
                        end else if (sum >= 33'(HALF)) begin
                            acc   <= sum[31:0] - 32'(HALF);
                            audio <= ~audio;
                        end else begin
                            acc <= sum[31:0];
                        end
                        if (div_end) begin
                            div_cnt   <= '0;
                            beat_tick <= 1'b1;
                            if (beat_num < 8'(LAST_BEAT)) begin
                                beat_num <= beat_num + 8'd1;
                            end else if (bus.loop_en) begin
                                beat_num <= '0;
                            end else begin
                                state     <= DONE;
                                playing   <= 1'b0;
                                song_done <= 1'b1;
                                acc       <= '0;
                                audio     <= 1'b0;
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    audio <= 1'b0;
                    if (bus.play) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                DONE: begin
                    audio     <= 1'b0;
                    song_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.beat_num  = beat_num;
    assign bus.audio_out = audio;
    assign bus.beat_tick = beat_tick;
    assign bus.playing   = playing;
    assign bus.song_done = song_done;
endmodule

// File: tb/tb_music_player.sv
// Directed bench: a tick monitor pops expected beat/status records from a
// scoreboard queue; the main process drives play/restart/loop and checks timing.
module tb_music_player;
    localparam int unsigned MUTE = 20000;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] score [4];

    typedef struct {
        logic [7:0] beat;
        logic       done;
        logic       play;
    } exp_t;

    exp_t exp_q[$];

    music_player_if bus ();

    music_player #(
        .CLK_FREQ (1000),
        .BEAT_RATE(10),
        .LAST_BEAT(3),
        .MUTE_TONE(MUTE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // combinational score ROM model
    assign bus.tone_in = score[bus.beat_num[1:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic d, input logic p);
        exp_t e;
        e.beat = b;
        e.done = d;
        e.play = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_tick(input string name, input int limit, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.beat_tick && n < limit);
        if (!bus.beat_tick) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no beat_tick within %0d cycles", name, limit);
        end
        at = cyc;
    endtask

    task automatic audio_interval(input string name, input int limit, output int n);
        logic a0 = bus.audio_out;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.audio_out == a0 && n < limit);
        if (bus.audio_out == a0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: audio_out stuck at %0d for %0d cycles", name, a0, limit);
        end
    endtask

    // scoreboard monitor: every beat_tick must match the next queued record
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.beat_tick) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tick: got tick at beat %0d, expected none", bus.beat_num);
            end else begin
                e = exp_q.pop_front();
                check("tick_beat_num", bus.beat_num, e.beat);
                check("tick_song_done", bus.song_done, e.done);
                check("tick_playing", bus.playing, e.play);
            end
        end
    end

    initial begin
        int c0, t, tp, r, p, n, bad;

        rst_n = 1'b0;
        bus.play = 1'b0;
        bus.restart = 1'b0;
        bus.loop_en = 1'b0;
        for (int i = 0; i < 4; i++) score[i] = 32'd50;
        repeat (3) @(negedge clk);
        check("rst_beat_num", bus.beat_num, 0);
        check("rst_audio", bus.audio_out, 0);
        check("rst_tick", bus.beat_tick, 0);
        check("rst_playing", bus.playing, 0);
        check("rst_song_done", bus.song_done, 0);

        // ---- straight play, no loop ----
        rst_n = 1'b1;
        bus.play = 1'b1;
        c0 = cyc;
        push(8'd1, 1'b0, 1'b1);
        push(8'd2, 1'b0, 1'b1);
        push(8'd3, 1'b0, 1'b1);
        push(8'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("idle_to_play", bus.playing, 1);
        // edge 1 enters PLAY, edge 2 loads tone, acc reaches 450 before edge 12
        audio_interval("first_toggle", 40, n);
        check("first_toggle", n, 11);
        audio_interval("half_period_a", 40, n);
        check("half_period_a", n, 10);
        audio_interval("half_period_b", 40, n);
        check("half_period_b", n, 10);
        wait_tick("tick1", 200, t);
        check("tick1_time", t - c0, 101);
        tp = t;
        wait_tick("tick2", 200, t);
        check("tick2_spacing", t - tp, 100);
        tp = t;
        wait_tick("tick3", 200, t);
        check("tick3_spacing", t - tp, 100);
        tp = t;
        wait_tick("tick_done", 200, t);
        check("done_spacing", t - tp, 100);
        check("done_audio", bus.audio_out, 0);

        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.beat_num != 8'd3 || !bus.song_done || bus.playing || bus.audio_out) bad++;
        end
        check("done_holds", bad, 0);

        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        r = cyc;
        check("restart_beat_num", bus.beat_num, 0);
        check("restart_song_done", bus.song_done, 0);
        check("restart_playing", bus.playing, 0);

        // ---- looping ----
        bus.loop_en = 1'b1;
        push(8'd1, 1'b0, 1'b1);
        push(8'd2, 1'b0, 1'b1);
        push(8'd3, 1'b0, 1'b1);
        push(8'd0, 1'b0, 1'b1);
        push(8'd1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) wait_tick("loop_tick", 200, t);
        check("loop_5th_tick_time", t - r, 501);

        // ---- pause at divider count 40 of beat 1 ----
        score[2] = MUTE;
        score[3] = 32'd0;
        repeat (40) @(negedge clk);
        bus.play = 1'b0;
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.audio_out || bus.beat_num != 8'd1 || bus.playing || bus.beat_tick) bad++;
        end
        check("pause_holds", bad, 0);
        bus.play = 1'b1;
        p = cyc;
        push(8'd2, 1'b0, 1'b1);
        // one edge back into PLAY, then 60 counts (40..99) to the tick
        wait_tick("resume_tick", 200, t);
        check("resume_tick_time", t - p, 61);

        // ---- mute tone on beat 2, zero tone on beat 3 ----
        score[1] = 32'd100;
        push(8'd3, 1'b0, 1'b1);
        push(8'd0, 1'b0, 1'b1);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.audio_out) bad++;
        end
        check("mute_audio_low", bad, 0);
        check("mute_wrap_tick", bus.beat_tick, 1);
        tp = cyc;

        // ---- 50 -> 100 Hz at a beat boundary ----
        push(8'd1, 1'b0, 1'b1);
        wait_tick("tone_change_tick", 200, t);
        check("tone_change_tick_time", t - tp, 100);
        @(negedge clk);
        check("note_start_low", bus.audio_out, 0);
        audio_interval("new_note_first", 40, n);
        check("new_note_first", n, 5);
        audio_interval("new_note_half_a", 40, n);
        check("new_note_half_a", n, 5);
        audio_interval("new_note_half_b", 40, n);
        check("new_note_half_b", n, 5);

        // ---- restart on the tick cycle ----
        while (cyc < t + 99) @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        r = cyc;
        check("restart_on_tick_no_tick", bus.beat_tick, 0);
        check("restart_on_tick_beat", bus.beat_num, 0);
        check("restart_on_tick_idle", bus.playing, 0);

        // ---- pause on the tick cycle ----
        while (cyc < r + 100) @(negedge clk);
        bus.play = 1'b0;
        @(negedge clk);
        check("pause_on_tick_no_tick", bus.beat_tick, 0);
        check("pause_on_tick_beat", bus.beat_num, 0);
        check("pause_on_tick_paused", bus.playing, 0);
        bus.play = 1'b1;
        p = cyc;
        push(8'd1, 1'b0, 1'b1);
        wait_tick("after_pause_tick", 20, t);
        check("after_pause_tick_time", t - p, 2);

        // ---- asynchronous reset mid-note ----
        n = 0;
        while (!bus.audio_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("audio_high_before_reset", bus.audio_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_beat_num", bus.beat_num, 0);
        check("async_audio", bus.audio_out, 0);
        check("async_playing", bus.playing, 0);
        check("async_song_done", bus.song_done, 0);
        @(negedge clk);
        bus.play = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
